// File: rtl/imm_gen_pipe.sv
// RV32I immediate generator: format decode, XLEN sign-extension, CSR zimm, illegal-opcode flag.
// One-cycle latency; valid/ready with a one-entry skid behind the output register, in_ready = !skid_valid.
module imm_gen_pipe #(
   parameter int XLEN        = 32,
   parameter int TAG_W       = 32,
   parameter int ENABLE_ZIMM = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_FENCE = 7'b0001111;

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_Z   = 3'd6;
   localparam logic [2:0] FMT_ILL = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } res_t;

   res_t              dec_res;
   logic signed [31:0] imm32;
   logic [2:0]        fmt;
   logic              illegal;

   res_t out_q, out_d;
   res_t skid_q, skid_d;
   logic out_vld_q, out_vld_d;
   logic skid_vld_q, skid_vld_d;

   logic accept;
   logic out_free;

   // imm32 is the 32-bit sign-extended immediate; zimm has bit 31 clear so widening is uniform.
   always_comb begin
      imm32   = '0;
      fmt     = FMT_ILL;
      illegal = 1'b0;
      case (in_instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR: begin
            fmt   = FMT_I;
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OP_SYS: begin
            if ((ENABLE_ZIMM != 0) && in_instr[14]) begin
               fmt   = FMT_Z;
               imm32 = {27'b0, in_instr[19:15]};
            end else begin
               fmt   = FMT_I;
               imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
         end
         OP_STORE: begin
            fmt   = FMT_S;
            imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OP_BR: begin
            fmt   = FMT_B;
            imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt   = FMT_U;
            imm32 = {in_instr[31:12], 12'b0};
         end
         OP_JAL: begin
            fmt   = FMT_J;
            imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
         end
         OP_REG, OP_FENCE: begin
            fmt   = FMT_R;
         end
         default: begin
            fmt     = FMT_ILL;
            illegal = 1'b1;
         end
      endcase
   end

   always_comb begin
      dec_res         = '0;
      dec_res.imm     = XLEN'(imm32);
      dec_res.fmt     = fmt;
      dec_res.illegal = illegal;
      dec_res.tag     = in_tag;
   end

   assign in_ready = ~skid_vld_q;
   assign accept   = in_valid & in_ready;
   assign out_free = ~out_vld_q | out_ready;

   // Skid drains first so ordering stays FIFO; a stalled output diverts the accept into the skid.
   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (out_free) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = accept;
            if (accept) begin
               skid_d = dec_res;
            end
         end else if (accept) begin
            out_d     = dec_res;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = dec_res;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign out_valid   = out_vld_q;
   assign out_imm     = out_q.imm;
   assign out_fmt     = out_q.fmt;
   assign out_illegal = out_q.illegal;
   assign out_tag     = out_q.tag;

endmodule
